// File: rtl/debug_pattern_core.sv
// Debug pattern generator: queues pixel coordinates in a small FIFO and shades
// each one into a registered output stage using the pattern selected at pop time.
module debug_pattern_core #(
  parameter int COORD_W    = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int TILE_SHIFT = 4,
  parameter int FRAME_BIT  = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [COORD_W-1:0]            in_x,
  input  logic [COORD_W-1:0]            in_y,
  output logic                          in_ready,
  input  logic [1:0]                    mode,
  input  logic [23:0]                   solid_color,
  input  logic [15:0]                   frame_counter,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COORD_W-1:0]            out_x,
  output logic [COORD_W-1:0]            out_y,
  output logic [23:0]                   out_color,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {S_IDLE, S_FULL} state_t;

  logic [2*COORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level_q, level_d;
  state_t               state_q, state_d;
  logic [COORD_W-1:0]   out_x_q, out_y_q;
  logic [23:0]          out_color_q;
  logic [COORD_W-1:0]   head_x, head_y;
  logic                 push, pop, fifo_empty;

  function automatic logic [23:0] shade(input logic [COORD_W-1:0] x,
                                        input logic [COORD_W-1:0] y,
                                        input logic [1:0]         m,
                                        input logic [23:0]        solid,
                                        input logic [15:0]        fc);
    logic               tile;
    logic [COORD_W-1:0] sx;
    tile = x[TILE_SHIFT] ^ y[TILE_SHIFT];
    // Horizontal scroll wraps within the coordinate width.
    sx   = x + COORD_W'(fc);
    case (m)
      2'd0:    shade = fc[FRAME_BIT] ? (tile ? 24'hFF0000 : 24'h00FF00)
                                     : (tile ? 24'hFFFF00 : 24'h00FFFF);
      2'd1:    shade = solid;
      2'd2:    shade = {8'(x), 8'(y), fc[7:0]};
      default: shade = (sx[TILE_SHIFT] ^ y[TILE_SHIFT]) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  // in_ready depends on registered level only, so a full FIFO never accepts a
  // push even when a pop happens in the same cycle.
  assign in_ready   = (level_q != LW'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign push       = in_valid && in_ready;
  assign pop        = !fifo_empty && (state_q == S_IDLE || out_ready);
  assign {head_x, head_y} = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pop) state_d = S_FULL;
      S_FULL:  if (out_ready && fifo_empty) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Stage 0: FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_x, in_y};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= S_IDLE;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      state_q <= state_d;
    end
  end

  // Stage 1: shaded output register
  always_ff @(posedge clk) begin
    if (reset) begin
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_color_q <= '0;
    end else if (pop) begin
      out_x_q     <= head_x;
      out_y_q     <= head_y;
      out_color_q <= shade(head_x, head_y, mode, solid_color, frame_counter);
    end
  end

  assign out_valid  = (state_q == S_FULL);
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign out_color  = out_color_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_debug_pattern_core.sv
// Directed bench for debug_pattern_core with default parameters (12-bit coords, depth 4).
module tb_debug_pattern_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [11:0] in_x, in_y;
  logic        in_ready;
  logic [1:0]  mode;
  logic [23:0] solid_color;
  logic [15:0] frame_counter;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_x, out_y;
  logic [23:0] out_color;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  debug_pattern_core dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .in_ready(in_ready), .mode(mode), .solid_color(solid_color),
    .frame_counter(frame_counter), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_color(out_color), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b1; in_x = 12'h005; in_y = 12'h005;
    tick; tick;
    reset = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%0b level=%0d ready=%0b required 0/0/1", out_valid, fifo_level, in_ready);
    end
    checks++;
    if (out_x !== 12'h0 || out_y !== 12'h0 || out_color !== 24'h0) begin
      errors++;
      $display("FAIL reset_data: x=%03h y=%03h color=%06h required zeros", out_x, out_y, out_color);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL reset_ignore_in: valid=%0b level=%0d required 0/0", out_valid, fifo_level);
    end
  endtask

  task automatic test_single;
    mode = 2'd0; frame_counter = 16'h0040; out_ready = 1'b1;
    in_x = 12'd16; in_y = 12'd0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd1) begin
      errors++;
      $display("FAIL single_edge1: valid=%0b level=%0d required 0/1", out_valid, fifo_level);
    end
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_color !== 24'hFF0000 || out_x !== 12'd16 || out_y !== 12'd0) begin
      errors++;
      $display("FAIL single_edge2: valid=%0b color=%06h xy=(%0d,%0d) required 1 FF0000 (16,0)",
               out_valid, out_color, out_x, out_y);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0; mode = 2'd2; frame_counter = 16'h0000; in_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      in_x = 12'(i); in_y = 12'(16 + i);
      tick;
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_x !== 12'd1 || out_y !== 12'd17 || fifo_level !== 3'd4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_fill: valid=%0b x=%0d y=%0d level=%0d ready=%0b required 1 1 17 4 0",
               out_valid, out_x, out_y, fifo_level, in_ready);
    end
    tick; tick;
    checks++;
    if (out_valid !== 1'b1 || out_x !== 12'd1 || out_color !== 24'h011100 || fifo_level !== 3'd4) begin
      errors++;
      $display("FAIL bp_hold: valid=%0b x=%0d color=%06h level=%0d required 1 1 011100 4",
               out_valid, out_x, out_color, fifo_level);
    end
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      tick;
      checks++;
      if (out_valid !== 1'b1 || out_x !== 12'(k) || out_color !== {8'(k), 8'(16 + k), 8'h00}) begin
        errors++;
        $display("FAIL bp_drain_%0d: valid=%0b x=%0d color=%06h required 1 %0d %06h",
                 k, out_valid, out_x, out_color, k, {8'(k), 8'(16 + k), 8'h00});
      end
    end
    tick;
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL bp_empty: valid=%0b level=%0d required 0/0", out_valid, fifo_level);
    end
  endtask

  task automatic test_full_pop;
    out_ready = 1'b0; mode = 2'd2; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_x = 12'(12'h021 + i); in_y = 12'h000;
      tick;
    end
    checks++;
    if (fifo_level !== 3'd4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fp_full: level=%0d ready=%0b required 4/0", fifo_level, in_ready);
    end
    in_x = 12'h099; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++;
    if (fifo_level !== 3'd3 || in_ready !== 1'b1 || out_x !== 12'h022) begin
      errors++;
      $display("FAIL fp_pop: level=%0d ready=%0b x=%03h required 3 1 022", fifo_level, in_ready, out_x);
    end
    for (int k = 12'h023; k <= 12'h025; k++) begin
      tick;
      checks++;
      if (out_valid !== 1'b1 || out_x !== 12'(k)) begin
        errors++;
        $display("FAIL fp_order: valid=%0b x=%03h required 1 %03h", out_valid, out_x, k);
      end
    end
    tick;
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL fp_no_extra: valid=%0b level=%0d required 0/0", out_valid, fifo_level);
    end
  endtask

  // Push-time pattern controls are deliberately wrong; only pop-time values count.
  task automatic shade_one(input logic [11:0] x, input logic [11:0] y, input logic [1:0] m,
                           input logic [15:0] fc, input logic [23:0] solid,
                           input logic [23:0] exp_color, input string nm);
    out_ready = 1'b1; in_x = x; in_y = y; in_valid = 1'b1;
    mode = ~m; frame_counter = ~fc; solid_color = ~solid;
    tick;
    in_valid = 1'b0; mode = m; frame_counter = fc; solid_color = solid;
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_color !== exp_color || out_x !== x || out_y !== y) begin
      errors++;
      $display("FAIL %s: valid=%0b color=%06h xy=(%03h,%03h) required 1 %06h (%03h,%03h)",
               nm, out_valid, out_color, out_x, out_y, exp_color, x, y);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: valid=%0b required 0", nm, out_valid);
    end
  endtask

  task automatic test_modes;
    shade_one(12'hFF8, 12'h000, 2'd3, 16'h0010, 24'h0, 24'h000000, "mode3_wrap");
    shade_one(12'h008, 12'h000, 2'd3, 16'h0010, 24'h0, 24'hFFFFFF, "mode3_tile");
    shade_one(12'h1AB, 12'h0CD, 2'd2, 16'h0077, 24'h0, 24'hABCD77, "mode2_grad");
    shade_one(12'h000, 12'h000, 2'd0, 16'h0000, 24'h0, 24'h00FFFF, "mode0_pal0_t0");
    shade_one(12'h010, 12'h000, 2'd0, 16'h0000, 24'h0, 24'hFFFF00, "mode0_pal0_t1");
    shade_one(12'h010, 12'h010, 2'd0, 16'h0040, 24'h0, 24'h00FF00, "mode0_pal1_t0");
    shade_one(12'h123, 12'h456, 2'd1, 16'h0000, 24'h123456, 24'h123456, "mode1_solid");
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1; mode = 2'd2; frame_counter = 16'h0000; in_y = 12'h003; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_x = 12'(12'h050 + i);
      tick;
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_x !== 12'(12'h050 + i - 1) || fifo_level !== 3'd1) begin
          errors++;
          $display("FAIL b2b_%0d: valid=%0b x=%03h level=%0d required 1 %03h 1",
                   i, out_valid, out_x, fifo_level, 12'h050 + i - 1);
        end
      end
    end
    in_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_x !== 12'h053 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL b2b_last: valid=%0b x=%03h level=%0d required 1 053 0", out_valid, out_x, fifo_level);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0; in_valid = 1'b1; in_y = 12'h001;
    for (int i = 0; i < 4; i++) begin
      in_x = 12'(12'h031 + i);
      tick;
    end
    checks++;
    if (fifo_level !== 3'd3 || out_valid !== 1'b1 || out_x !== 12'h031) begin
      errors++;
      $display("FAIL rm_setup: level=%0d valid=%0b x=%03h required 3 1 031", fifo_level, out_valid, out_x);
    end
    reset = 1'b1; in_x = 12'h077;
    tick;
    reset = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0 || out_x !== 12'h0 || out_color !== 24'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rm_after: valid=%0b level=%0d x=%03h color=%06h ready=%0b required 0 0 000 000000 1",
               out_valid, fifo_level, out_x, out_color, in_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++;
      if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
        errors++;
        $display("FAIL rm_quiet_%0d: valid=%0b level=%0d required 0/0", c, out_valid, fifo_level);
      end
    end
    in_x = 12'h040; in_y = 12'h002; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_x !== 12'h040 || out_y !== 12'h002) begin
      errors++;
      $display("FAIL rm_new: valid=%0b xy=(%03h,%03h) required 1 (040,002)", out_valid, out_x, out_y);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_new_drain: valid=%0b required 0", out_valid);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; mode = 2'd0;
    solid_color = '0; frame_counter = '0; out_ready = 1'b0;
    test_reset;
    test_single;
    test_backpressure;
    test_full_pop;
    test_modes;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_pattern_core.md
DEBUG_PATTERN_CORE -- requirements
Module: debug_pattern_core

Interface
REQ-001 Parameter COORD_W, default 12: pixel coordinate width in bits.
REQ-002 Parameter FIFO_DEPTH, default 4: input FIFO entries; SHALL be a power of two, 2 or greater.
REQ-003 Parameter TILE_SHIFT, default 4: coordinate bit that selects the checker tile; range 0..COORD_W-1.
REQ-004 Parameter FRAME_BIT, default 6: frame_counter bit that selects the checker palette; range 0..15.
REQ-005 Clocking: one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 in_valid  in  1  an input pixel is offered.
REQ-009 in_x, in_y  in  COORD_W each  input pixel coordinates.
REQ-010 in_ready  out  1  the FIFO can accept a pixel (not full).
REQ-011 mode  in  2  pattern select.
REQ-012 solid_color  in  24  {R,G,B} colour used by mode 1.
REQ-013 frame_counter  in  16  frame index.
REQ-014 out_valid  out  1  output register holds a shaded pixel.
REQ-015 out_ready  in  1  the consumer accepts the output pixel.
REQ-016 out_x, out_y  out  COORD_W each  coordinates of the shaded pixel.
REQ-017 out_color  out  24  {R[23:16],G[15:8],B[7:0]}.
REQ-018 fifo_level  out  $clog2(FIFO_DEPTH)+1  current number of FIFO entries.

Function
REQ-019 Push: a push SHALL occur when in_valid && in_ready; in_ready SHALL equal (fifo_level != FIFO_DEPTH), driven from registered state only.
REQ-020 At FIFO full, a pop in the same cycle SHALL NOT permit a push; in_ready SHALL rise in the cycle after the pop.
REQ-021 Pop: a pop SHALL occur when the FIFO is non-empty && (!out_valid || out_ready); the popped entry SHALL be shaded and loaded into the output register in the same edge.
REQ-022 Latency: a pixel pushed at edge k into an empty FIFO with an idle output SHALL appear with out_valid=1 after edge k+1.
REQ-023 Throughput: one pixel per cycle sustained while out_ready=1.
REQ-024 Simultaneous push and pop SHALL leave fifo_level unchanged; FIFO order SHALL be strict FIFO.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 Output hold: while out_valid && !out_ready, out_x, out_y and out_color SHALL hold stable.
REQ-027 out_valid SHALL clear on an out_ready handshake when the FIFO is empty.
REQ-028 mode, solid_color and frame_counter SHALL be sampled at pop time, not push time.
REQ-029 Define tile = x[TILE_SHIFT] ^ y[TILE_SHIFT].
REQ-030 Mode 0: if frame_counter[FRAME_BIT]=1, colour = tile ? FF0000 : 00FF00; otherwise colour = tile ? FFFF00 : 00FFFF.
REQ-031 Mode 1: colour = solid_color.
REQ-032 Mode 2: R = x[7:0], G = y[7:0], B = frame_counter[7:0]; coordinate bits above COORD_W SHALL read as zero.
REQ-033 Mode 3: sx = (x + frame_counter) truncated to COORD_W (wrap-around); colour = (sx[TILE_SHIFT] ^ y[TILE_SHIFT]) ? FFFFFF : 000000.
REQ-034 FSM per output register has two states. IDLE -> FULL on pop. FULL -> FULL on pop with handshake. FULL -> IDLE on handshake with the FIFO empty.

Reset
REQ-035 While reset=1 at an edge: fifo_level=0, pointers=0, out_valid=0, out_x=0, out_y=0, out_color=0, in_ready=1 from the next cycle.
REQ-036 Reset mid-operation SHALL discard all FIFO contents and the output pixel; no stale pixel SHALL emerge after reset.
REQ-037 in_valid during reset SHALL be ignored.

Verification
REQ-038 Single pixel, mode 0, frame_counter=0x0040, in (16,0), out_ready=1 -> out_valid after 2 edges, out_color=FF0000, out (16,0).
REQ-039 Backpressure, FIFO_DEPTH=4, out_ready=0, 6 pushes offered -> 1 pixel in the output register, fifo_level=4, in_ready=0; then out_ready=1 -> 5 pixels out in order.
REQ-040 Full with simultaneous pop -> no push accepted that cycle, level goes 4->3, in_ready=1 next cycle.
REQ-041 Mode 3, COORD_W=12, x=0xFF8, frame_counter=0x0010, y=0 -> sx=0x008, colour=000000; mode 2, x=0x1AB, y=0x0CD, fc=0x0077 -> ABCD77.
REQ-042 Reset asserted with 3 entries queued and out_valid=1 -> after release out_valid=0, fifo_level=0, and no output until a new push.
